// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI initiator serializing {op, data} frames and capturing 8-bit read replies.
module spi_master_ctrl #(
  parameter int RD_LAT = 2,
  parameter int GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       ss_n,
  output logic       MOSI,
  input  logic       MISO
);
  typedef enum logic [2:0] {IDLE, START, SEL, SHIFT, WAIT, RECV, GAP_ST} state_t;
  state_t state;
  logic [9:0] sh;
  logic [3:0] cnt;
  logic [7:0] rx;
  logic rd;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ss_n <= 1'b1;
      MOSI <= 1'b0;
      cmd_ready <= 1'b1;
      busy <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= 8'h00;
      sh <= '0;
      cnt <= '0;
      rx <= '0;
      rd <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          state <= START;
          sh <= {cmd_op, cmd_data};
          rd <= cmd_op == 2'b11;
          ss_n <= 1'b0;
          MOSI <= 1'b0;
          cmd_ready <= 1'b0;
          busy <= 1'b1;
        end
        START: begin
          state <= SEL;
          MOSI <= sh[9];
        end
        // op[1] goes out twice: once as the selector bit, once as the first frame bit
        SEL: begin
          state <= SHIFT;
          MOSI <= sh[9];
          sh <= {sh[8:0], 1'b0};
          cnt <= '0;
        end
        SHIFT: if (cnt == 4'd9) begin
          state <= rd ? WAIT : GAP_ST;
          ss_n <= !rd;
          MOSI <= 1'b0;
          cnt <= '0;
        end else begin
          MOSI <= sh[9];
          sh <= {sh[8:0], 1'b0};
          cnt <= cnt + 4'd1;
        end
        WAIT: if (cnt == 4'(RD_LAT - 1)) begin
          state <= RECV;
          cnt <= '0;
        end else cnt <= cnt + 4'd1;
        RECV: begin
          rx <= {rx[6:0], MISO};
          if (cnt == 4'd7) begin
            state <= GAP_ST;
            ss_n <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_data <= {rx[6:0], MISO};
            cnt <= '0;
          end else cnt <= cnt + 4'd1;
        end
        GAP_ST: if (cnt == 4'(GAP - 1)) begin
          state <= IDLE;
          cmd_ready <= 1'b1;
          busy <= 1'b0;
          cnt <= '0;
        end else cnt <= cnt + 4'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: randomized frame-level checks of spi_master_ctrl against a per-cycle timing model.
module tb_spi_master_ctrl;
  localparam int RD_LAT = 2;
  localparam int GAP = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic rsp_valid;
  logic [7:0] rsp_data;
  logic busy, ss_n, mosi;
  logic miso = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [7:0] last_rsp = 8'h00;
  spi_master_ctrl #(.RD_LAT(RD_LAT), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .ss_n(ss_n), .MOSI(mosi), .MISO(miso)
  );
  always #5 clk = ~clk;
  task automatic issue(input logic [1:0] op, input logic [7:0] d);
    int k = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_wait cmd_ready=%b required=1 after %0d cycles", cmd_ready, k);
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = d;
  endtask
  // Runs one accepted frame cycle by cycle; cycle 1 is the cycle right after acceptance.
  task automatic run_frame(input logic [1:0] op, input logic [7:0] d, input logic [7:0] rxb,
                           input bit hold, input logic [1:0] nop, input logic [7:0] nd, input bit poke);
    logic [9:0] f;
    bit rdop;
    int first_rx, last_low, len;
    logic [4:0] got, want;
    f = {op, d};
    rdop = op == 2'b11;
    first_rx = 13 + RD_LAT;
    last_low = rdop ? 20 + RD_LAT : 12;
    len = rdop ? 21 + RD_LAT + GAP : 13 + GAP;
    for (int n = 1; n <= len; n++) begin
      @(negedge clk);
      if (n == 1 && !hold) cmd_valid = 1'b0;
      if (poke && n == 5) begin
        cmd_valid = 1'b1;
        cmd_op = 2'b01;
        cmd_data = 8'hFF;
      end
      if (poke && n == 6) cmd_valid = 1'b0;
      if (rdop && n == 21 + RD_LAT) last_rsp = rxb;
      want[4] = n > last_low;
      want[3] = n == 2 ? op[1] : (n >= 3 && n <= 12) ? f[12 - n] : 1'b0;
      want[2] = n == len;
      want[1] = n != len;
      want[0] = rdop && n == 21 + RD_LAT;
      got = {ss_n, mosi, cmd_ready, busy, rsp_valid};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL frame op=%b data=%h cycle %0d {ss_n,mosi,ready,busy,rsp_valid}=%b required=%b",
                 op, d, n, got, want);
      end
      checks++;
      if (rsp_data !== last_rsp) begin
        failures++;
        $display("FAIL rsp_data op=%b cycle %0d got=%h required=%h", op, n, rsp_data, last_rsp);
      end
      miso = (rdop && n >= first_rx && n < first_rx + 8) ? rxb[7 - (n - first_rx)] : 1'($urandom);
      if (n == len && hold) begin
        cmd_op = nop;
        cmd_data = nd;
      end
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_data = 8'h2A;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({ss_n, mosi, cmd_ready, busy, rsp_valid, rsp_data} !== {5'b10100, 8'h00}) begin
        failures++;
        $display("FAIL reset_values got=%b required=%b",
                 {ss_n, mosi, cmd_ready, busy, rsp_valid, rsp_data}, {5'b10100, 8'h00});
      end
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({ss_n, cmd_ready, busy} !== 3'b110) begin
      failures++;
      $display("FAIL reset_no_accept {ss_n,ready,busy}=%b required=110", {ss_n, cmd_ready, busy});
    end
  endtask
  task automatic test_write_addr();
    issue(2'b00, 8'h2A);
    run_frame(2'b00, 8'h2A, 8'h00, 1'b0, 2'b00, 8'h00, 1'b0);
  endtask
  task automatic test_read();
    logic [7:0] d = 8'($urandom);
    issue(2'b11, d);
    run_frame(2'b11, d, 8'hA5, 1'b0, 2'b00, 8'h00, 1'b0);
  endtask
  task automatic test_back_to_back();
    logic [7:0] d [4];
    for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
    issue(2'b00, d[0]);
    for (int i = 0; i < 4; i++)
      run_frame(2'(i), d[i], 8'($urandom), i < 3, 2'(i + 1), d[(i + 1) % 4], 1'b0);
  endtask
  task automatic test_busy_ignore();
    logic [7:0] d = 8'($urandom);
    issue(2'b01, d);
    run_frame(2'b01, d, 8'h00, 1'b0, 2'b00, 8'h00, 1'b1);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({ss_n, cmd_ready, busy} !== 3'b110) begin
        failures++;
        $display("FAIL busy_ignore {ss_n,ready,busy}=%b required=110", {ss_n, cmd_ready, busy});
      end
    end
  endtask
  task automatic test_random();
    logic [1:0] op [11];
    logic [7:0] d [11];
    logic [7:0] r [11];
    bit h;
    for (int i = 0; i < 11; i++) begin
      op[i] = 2'($urandom);
      d[i] = 8'($urandom);
      r[i] = 8'($urandom);
    end
    issue(op[0], d[0]);
    for (int i = 0; i < 10; i++) begin
      h = i < 9 && $urandom_range(0, 1) == 1;
      run_frame(op[i], d[i], r[i], h, op[i + 1], d[i + 1], 1'b0);
      if (!h && i < 9) issue(op[i + 1], d[i + 1]);
    end
  endtask
  task automatic test_mid_reset();
    logic [7:0] d = 8'($urandom);
    issue(2'b11, d);
    for (int n = 1; n <= 15 + RD_LAT; n++) begin
      @(negedge clk);
      if (n == 1) cmd_valid = 1'b0;
      miso = 1'($urandom);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rsp = 8'h00;
    checks++;
    if ({ss_n, mosi, cmd_ready, busy, rsp_valid, rsp_data} !== {5'b10100, 8'h00}) begin
      failures++;
      $display("FAIL mid_reset got=%b required=%b",
               {ss_n, mosi, cmd_ready, busy, rsp_valid, rsp_data}, {5'b10100, 8'h00});
    end
    repeat (8) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || ss_n !== 1'b1) begin
        failures++;
        $display("FAIL mid_reset_abandon rsp_valid=%b ss_n=%b required 0 and 1", rsp_valid, ss_n);
      end
    end
    d = 8'($urandom);
    issue(2'b11, d);
    run_frame(2'b11, d, 8'($urandom), 1'b0, 2'b00, 8'h00, 1'b0);
  endtask
  initial begin
    test_reset();
    test_write_addr();
    test_read();
    test_back_to_back();
    test_busy_ignore();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
